// File: rtl/idex_pkg.sv
// rtl/idex_pkg.sv - shared types and constants for the ID/EX pipeline register
// Contents: CTRL_W, ctrl_t control-bundle layout, CTRL_NOP, FSM state encoding.
package idex_pkg;

    localparam int CTRL_W = 22;

    // Decoded control bundle, MSB first.
    typedef struct packed {
        logic       branch;
        logic [2:0] branch_op;
        logic       jump;
        logic       jump_reg;
        logic       alu_src1;
        logic       alu_src2;
        logic       ext_op;
        logic       lu_op;
        logic [4:0] alu_op;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_to_reg;
    } ctrl_t;

    // All-zero bundle: no register write, no memory access, no control transfer.
    localparam ctrl_t CTRL_NOP = '0;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        HOLD       = 2'd1,
        FLUSH_PEND = 2'd2
    } state_t;

endpackage

// File: rtl/idex_hazard_detect.sv
// rtl/idex_hazard_detect.sv - combinational load-use hazard detector
// Ports:
//   id_valid, id_rs_addr, id_rt_addr : instruction currently in ID
//   ex_valid, ex_mem_read, ex_wr_addr : instruction currently in EX
//   lu                                : ID reads the register a load in EX is about to write
// DETECT_EN=0 ties lu low.
module idex_hazard_detect #(
    parameter int REG_AW    = 5,
    parameter bit DETECT_EN = 1'b1
) (
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs_addr,
    input  logic [REG_AW-1:0] id_rt_addr,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_wr_addr,
    output logic              lu
);

    logic addr_hit;

    // $0 is hard-wired, so a load targeting it never creates a dependency.
    assign addr_hit = (ex_wr_addr != '0) &&
                      ((ex_wr_addr == id_rs_addr) || (ex_wr_addr == id_rt_addr));

    assign lu = DETECT_EN && id_valid && ex_valid && ex_mem_read && addr_hit;

endmodule

// File: rtl/id_ex_pipe.sv
// rtl/id_ex_pipe.sv - ID/EX pipeline register with flush, back-pressure and load-use bubbles
// Ports:
//   clk, reset (async, active-low)
//   id_* : instruction from ID (valid, ctrl, register indices, operands, imm, pc8, shamt)
//   flush : ID instruction is wrong-path;  ex_ready : EX accepts a new instruction
//   ex_* : registered EX-stage copies;  stall_id : freeze PC and IF/ID this cycle
//   bubble_cnt : saturating count of load-use bubbles
// Optional feature macro: IDEX_LOAD_USE_DETECT_EN (load-use detection and bubble counting).
module id_ex_pipe
    import idex_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  ctrl_t             id_ctrl,
    input  logic [REG_AW-1:0] id_rs_addr,
    input  logic [REG_AW-1:0] id_rt_addr,
    input  logic [REG_AW-1:0] id_wr_addr,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc8,
    input  logic [4:0]        id_shamt,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output ctrl_t             ex_ctrl,
    output logic [REG_AW-1:0] ex_rs_addr,
    output logic [REG_AW-1:0] ex_rt_addr,
    output logic [REG_AW-1:0] ex_wr_addr,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc8,
    output logic [4:0]        ex_shamt,
    output logic              stall_id,
    output logic [CNT_W-1:0]  bubble_cnt
);

`ifdef IDEX_LOAD_USE_DETECT_EN
    localparam bit LU_DETECT_EN = 1'b1;
`else
    localparam bit LU_DETECT_EN = 1'b0;
`endif

    state_t state, next_state;
    logic   lu;
    logic   adv;
    logic   kill;
    logic   load_bubble;
    logic   load_id;
    logic   count_bubble;

    idex_hazard_detect #(
        .REG_AW    (REG_AW),
        .DETECT_EN (LU_DETECT_EN)
    ) u_hazard (
        .id_valid    (id_valid),
        .id_rs_addr  (id_rs_addr),
        .id_rt_addr  (id_rt_addr),
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_ctrl.mem_read),
        .ex_wr_addr  (ex_wr_addr),
        .lu          (lu)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        adv          = ex_ready || !ex_valid;
        // A flush seen while EX was stalled is remembered until the bubble can load.
        kill         = flush || (state == FLUSH_PEND);
        load_bubble  = 1'b0;
        load_id      = 1'b0;
        count_bubble = 1'b0;
        stall_id     = !adv || (lu && !kill);
        next_state   = RUN;

        if (!adv) begin
            next_state = kill ? FLUSH_PEND : HOLD;
        end else if (kill) begin
            load_bubble = 1'b1;
        end else if (lu) begin
            load_bubble  = 1'b1;
            count_bubble = 1'b1;
        end else begin
            load_id = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid   <= 1'b0;
            ex_ctrl    <= CTRL_NOP;
            ex_rs_addr <= '0;
            ex_rt_addr <= '0;
            ex_wr_addr <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_pc8     <= '0;
            ex_shamt   <= '0;
        end else if (load_bubble) begin
            ex_valid   <= 1'b0;
            ex_ctrl    <= CTRL_NOP;
            ex_rs_addr <= '0;
            ex_rt_addr <= '0;
            ex_wr_addr <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_pc8     <= '0;
            ex_shamt   <= '0;
        end else if (load_id) begin
            ex_valid   <= id_valid;
            // An invalid slot must never carry side-effecting control bits.
            ex_ctrl    <= id_valid ? id_ctrl : CTRL_NOP;
            ex_rs_addr <= id_rs_addr;
            ex_rt_addr <= id_rt_addr;
            ex_wr_addr <= id_wr_addr;
            ex_rs_data <= id_rs_data;
            ex_rt_data <= id_rt_data;
            ex_imm     <= id_imm;
            ex_pc8     <= id_pc8;
            ex_shamt   <= id_shamt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_cnt <= '0;
        end else if (count_bubble && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule
